alu_sequencer: RTL and testbench
================================

# alu_sequencer

Multi-cycle execution sequencer for the integer ALU. Accepts one operation at a time, using the 3-bit ALU operation code produced by ALU control. Single-cycle operations complete on the accept edge; `mul` runs as an iterative shift-add over WIDTH cycles. While `mul` is running, the block drops `ready_o`, which serves as the pipeline stall source.

## Interface

Parameters:
- `WIDTH`, default 32: operand/result width; must be a power of two, ≥ 8.
- `SHW`, default log2(WIDTH) = 5: shift-amount bits taken from `b_i`.

Ports:
- `clk_i`, in, 1: clock, rising edge.
- `rst_i`, in, 1: reset, asynchronous, active-low.
- `start_i`, in, 1: request valid; sampled only when `ready_o`=1.
- `op_i`, in, 3: 0 and, 1 xor, 2 sll, 3 add, 4 sub, 5 mul, 6 srai, 7 reserved.
- `a_i`, in, WIDTH: operand A.
- `b_i`, in, WIDTH: operand B; shift amount is `b_i[SHW-1:0]`.
- `ready_o`, out, 1: able to accept a request.
- `done_o`, out, 1: one-cycle pulse, `result_o` updated.
- `result_o`, out, WIDTH: registered result, held until the next completion.

## Operation

- Accept happens on a rising edge with `start_i`=1 and `ready_o`=1. `op_i`, `a_i` and `b_i` are sampled on that edge only. `start_i` is ignored while `ready_o`=0; there is no queueing.
- States:
  - IDLE: `ready_o`=1.
  - MUL: `ready_o`=0.
- IDLE, accept with op ≠ 5:
  - On the accept edge: `result_o` ← f(a,b) and `done_o` ← 1.
  - Stay in IDLE.
- Single-cycle functions:
  - and, xor, add, sub: WIDTH-bit, wrap modulo 2^WIDTH, no carry or overflow output.
  - sll: `a << b[SHW-1:0]`, zero fill.
  - srai: arithmetic right shift by `b[SHW-1:0]`, sign fill.
  - op 7: `result_o` ← 0, `done_o` pulses normally.
- IDLE, accept with op = 5:
  - Load acc ← 0, mcand ← a, mplier ← b, cnt ← 0.
  - Go to MUL. `done_o` stays 0.
- MUL, each edge (one iteration):
  - If mplier[0], acc ← acc + mcand (WIDTH-bit wrap).
  - mcand ← mcand << 1; mplier ← mplier >> 1 (logical); cnt ← cnt + 1.
  - On the edge where cnt = WIDTH-1 (the WIDTH-th iteration):
    - `result_o` ← the updated acc, i.e. the low WIDTH bits of a×b, unsigned/signed agnostic.
    - `done_o` ← 1; go to IDLE.
- `cnt` is log2(WIDTH) bits wide. It never wraps: the terminal count forces the exit to IDLE.
- `done_o` is cleared on every edge on which no completion occurs.

## Timing

- Reset (asynchronous, any state, including mid-MUL):
  - State ← IDLE; `ready_o`=1, `done_o`=0, `result_o`=0.
  - acc, mcand, mplier and cnt ← 0.
  - The in-flight `mul` is discarded. No `done_o` follows reset release.
- Latency is counted as edges from the accept edge, inclusive:
  - Single-cycle ops: 1 (results visible in the cycle after accept).
  - `mul`: WIDTH+1. `ready_o` is low for exactly WIDTH cycles.
- `ready_o` is combinational from state: it is 1 in the cycle `done_o` is high after a `mul`. A new request is therefore accepted back-to-back on the next edge.
- Consecutive single-cycle requests complete once per cycle with `done_o` held high.
- Input changes during MUL have no effect.

## Configuration

- Macro: `ALU_SEQ_MUL_EARLY_EXIT_EN`.
- Defined:
  - At accept, a `mul` with b = 0 completes on the accept edge: `result_o`=0, latency 1, no MUL entry.
  - In MUL, the block finishes on the edge where the post-shift mplier = 0, or cnt = WIDTH-1, whichever comes first.
  - Latency for b ≠ 0 is 2 + (index of the highest set bit of b).
  - Result is identical to the non-early-exit result.
- Undefined: fixed WIDTH+1 latency for every `mul`, including b = 0.

## Test plan

- Reset, then add a=3, b=4: after 1 edge `result_o`=7, `done_o`=1 for one cycle; then sub a=3, b=4 gives 0xFFFFFFFF.
- srai a=0x80000000, b=4 gives 0xF8000000; sll a=1, b=0x21 (shamt 1) gives 2; op 7 gives 0 with a done pulse.
- mul a=6, b=7, macro undefined: `ready_o`=0 for 32 cycles, `done_o` 33 edges after accept, `result_o`=42. A `start_i` with add asserted mid-MUL is ignored, and `result_o` stays unchanged until done.
- mul a=0xFFFFFFFF, b=0xFFFFFFFF gives 1. An add issued on the `done_o` cycle is accepted on the next edge and completes 1 edge later.
- Assert `rst_i`=0 at cycle 10 of a `mul`: outputs immediately `ready_o`=1, `done_o`=0, `result_o`=0. No late done pulse after release.
- With `ALU_SEQ_MUL_EARLY_EXIT_EN`:
  - mul a=9, b=5 gives 45 with latency 4.
  - mul with b=0 gives 0 with latency 1.
  - b=0x80000000 gives latency 33.

Source files
------------

// File: rtl/alu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : alu_sequencer
//  Description : Multi-cycle execution sequencer for the integer ALU.
//                Single-cycle ops (and/xor/sll/add/sub/srai/reserved) finish
//                on the accept edge; mul runs as a WIDTH-step shift-add loop
//                during which ready_o is low (pipeline stall source).
//                Optional feature macro: ALU_SEQ_MUL_EARLY_EXIT_EN
//                (mul ends as soon as the remaining multiplier bits are zero).
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_sequencer #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [2:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             ready_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o
);

    localparam int              CNTW       = $clog2(WIDTH);
    localparam logic [CNTW-1:0] C_CNT_LAST = CNTW'(WIDTH - 1);

    localparam logic [2:0] C_OP_AND  = 3'd0;
    localparam logic [2:0] C_OP_XOR  = 3'd1;
    localparam logic [2:0] C_OP_SLL  = 3'd2;
    localparam logic [2:0] C_OP_ADD  = 3'd3;
    localparam logic [2:0] C_OP_SUB  = 3'd4;
    localparam logic [2:0] C_OP_MUL  = 3'd5;
    localparam logic [2:0] C_OP_SRAI = 3'd6;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_t;

    state_t            r_state;
    logic [WIDTH-1:0]  r_acc;
    logic [WIDTH-1:0]  r_mcand;
    logic [WIDTH-1:0]  r_mplier;
    logic [CNTW-1:0]   r_cnt;
    logic              r_done;
    logic [WIDTH-1:0]  r_result;

    logic [SHW-1:0]    w_shamt;
    logic [WIDTH-1:0]  w_alu_result;
    logic [WIDTH-1:0]  w_acc_next;
    logic [WIDTH-1:0]  w_mplier_next;
    logic              w_mul_last;
    logic              w_accept;
    logic              w_start_mul;

    // Ready is a pure function of state so a new request can follow a mul
    // completion back-to-back.
    assign ready_o  = (r_state == S_IDLE);
    assign done_o   = r_done;
    assign result_o = r_result;

    assign w_shamt  = b_i[SHW-1:0];
    assign w_accept = start_i && ready_o;

`ifdef ALU_SEQ_MUL_EARLY_EXIT_EN
    // A zero multiplier needs no iterations: it takes the single-cycle path
    // and produces 0 from the combinational result below.
    assign w_start_mul = (op_i == C_OP_MUL) && (b_i != '0);
`else
    assign w_start_mul = (op_i == C_OP_MUL);
`endif

    // Single-cycle function unit; mul and the reserved code yield zero here.
    always_comb begin
        w_alu_result = '0;
        case (op_i)
            C_OP_AND:  w_alu_result = a_i & b_i;
            C_OP_XOR:  w_alu_result = a_i ^ b_i;
            C_OP_SLL:  w_alu_result = a_i << w_shamt;
            C_OP_ADD:  w_alu_result = a_i + b_i;
            C_OP_SUB:  w_alu_result = a_i - b_i;
            C_OP_SRAI: w_alu_result = $unsigned($signed(a_i) >>> w_shamt);
            default:   w_alu_result = '0;
        endcase
    end

    // One shift-add iteration and the terminal-iteration detect.
    always_comb begin
        w_acc_next    = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
        w_mplier_next = r_mplier >> 1;
`ifdef ALU_SEQ_MUL_EARLY_EXIT_EN
        w_mul_last    = (r_cnt == C_CNT_LAST) || (w_mplier_next == '0);
`else
        w_mul_last    = (r_cnt == C_CNT_LAST);
`endif
    end

    // Sequencer FSM with registered done/result; reset discards any mul.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state  <= S_IDLE;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
            r_done   <= 1'b0;
            r_result <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (w_start_mul) begin
                            r_acc    <= '0;
                            r_mcand  <= a_i;
                            r_mplier <= b_i;
                            r_cnt    <= '0;
                            r_state  <= S_MUL;
                        end else begin
                            r_result <= w_alu_result;
                            r_done   <= 1'b1;
                        end
                    end
                end
                S_MUL: begin
                    r_acc    <= w_acc_next;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= w_mplier_next;
                    if (w_mul_last) begin
                        // Counter is parked at zero instead of wrapping.
                        r_cnt    <= '0;
                        r_result <= w_acc_next;
                        r_done   <= 1'b1;
                        r_state  <= S_IDLE;
                    end else begin
                        r_cnt    <= r_cnt + CNTW'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_sequencer
//  Description : Scoreboard bench for alu_sequencer. Stimulus pushes expected
//                result and completion cycle; a monitor compares on done_o,
//                and checks ready_o and result hold every cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_sequencer;

    localparam int W  = 32;
    localparam int SH = $clog2(W);

    logic         clk = 1'b0;
    logic         rst_i = 1'b0;
    logic         start_i = 1'b0;
    logic [2:0]   op_i = '0;
    logic [W-1:0] a_i = '0;
    logic [W-1:0] b_i = '0;
    logic         ready_o;
    logic         done_o;
    logic [W-1:0] result_o;

    alu_sequencer #(.WIDTH(W), .SHW(SH)) dut (
        .clk_i    (clk),
        .rst_i    (rst_i),
        .start_i  (start_i),
        .op_i     (op_i),
        .a_i      (a_i),
        .b_i      (b_i),
        .ready_o  (ready_o),
        .done_o   (done_o),
        .result_o (result_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] res;
        int           cyc;
    } exp_t;

    exp_t         q[$];
    int           cyc = 0;
    logic [W-1:0] last_res = '0;
    int           busy_from = 0;
    int           busy_until = 0;
    int           cmp_cnt = 0;
    int           err_cnt = 0;

    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int msb_index(input logic [W-1:0] v);
        int m = 0;
        for (int i = 0; i < W; i++) if (v[i]) m = i;
        return m;
    endfunction

    // Reference behaviour straight from the operation table.
    function automatic logic [W-1:0] ref_result(input logic [2:0] op, input logic [W-1:0] a,
                                                input logic [W-1:0] b);
        logic signed [W-1:0] sa;
        int sh;
        sa = a;
        sh = int'(b % W);
        case (op)
            3'd0: return a & b;
            3'd1: return a ^ b;
            3'd2: return a << sh;
            3'd3: return a + b;
            3'd4: return a - b;
            3'd5: return a * b;
            3'd6: return sa >>> sh;
            default: return '0;
        endcase
    endfunction

    function automatic int ref_latency(input logic [2:0] op, input logic [W-1:0] b);
        if (op != 3'd5) return 1;
`ifdef ALU_SEQ_MUL_EARLY_EXIT_EN
        if (b == '0) return 1;
        return 2 + msb_index(b);
`else
        return W + 1;
`endif
    endfunction

    // Drive one request at the first negedge where the DUT is ready.
    task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        int guard = 0;
        int e, l;
        exp_t x;
        @(negedge clk);
        while (!ready_o && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!ready_o) begin
            cmp_cnt++;
            err_cnt++;
            $display("FAIL ready_timeout: ready_o stuck at 0 for %0d cycles", guard);
        end
        start_i = 1'b1;
        op_i    = op;
        a_i     = a;
        b_i     = b;
        e = cyc + 1;
        l = ref_latency(op, b);
        x.res = ref_result(op, a, b);
        x.cyc = e + l - 1;
        q.push_back(x);
        if (l > 1) begin
            busy_from  = e;
            busy_until = e + l - 1;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            start_i = 1'b0;
        end
    endtask

    // Monitor: sampled 1 time unit after each rising edge.
    always @(posedge clk) begin
        exp_t x;
        #1;
        if (rst_i) begin
            check("ready", {{(W-1){1'b0}}, ready_o},
                  {{(W-1){1'b0}}, !(cyc >= busy_from && cyc < busy_until)});
            if (done_o) begin
                if (q.size() == 0) begin
                    cmp_cnt++;
                    err_cnt++;
                    $display("FAIL unexpected_done: got done_o=1 expected no completion (cycle %0d)", cyc);
                end else begin
                    x = q.pop_front();
                    check("result", result_o, x.res);
                    check("done_cycle", W'(cyc), W'(x.cyc));
                    last_res = x.res;
                end
            end else begin
                check("result_hold", result_o, last_res);
            end
        end
    end

    initial begin
        int guard;
        // Reset state
        #2;
        check("rst_ready", {{(W-1){1'b0}}, ready_o}, W'(1));
        check("rst_done", {{(W-1){1'b0}}, done_o}, W'(0));
        check("rst_result", result_o, '0);
        repeat (2) @(negedge clk);
        rst_i = 1'b1;

        // Directed single-cycle cases
        issue(3'd3, 32'd3, 32'd4);
        idle(1);
        issue(3'd4, 32'd3, 32'd4);
        issue(3'd6, 32'h8000_0000, 32'd4);
        issue(3'd2, 32'd1, 32'h21);
        issue(3'd7, 32'h1234_5678, 32'h9abc_def0);
        issue(3'd0, 32'hF0F0_F0F0, 32'hFF00_FF00);
        issue(3'd1, 32'hF0F0_F0F0, 32'hFF00_FF00);
        idle(2);

        // mul 6*7 with an add request during the busy window
        issue(3'd5, 32'd6, 32'd7);
        repeat (5) begin
            @(negedge clk);
            start_i = 1'b1;
            op_i    = 3'd3;
            a_i     = $urandom;
            b_i     = $urandom;
        end
        idle(40);

        // Full-width mul followed immediately by an add on the done cycle
        issue(3'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        issue(3'd3, 32'd100, 32'd23);
        idle(2);

        // Early-exit relevant multipliers
        issue(3'd5, 32'd9, 32'd5);
        issue(3'd5, 32'd12345, 32'd0);
        issue(3'd5, 32'd3, 32'h8000_0000);
        idle(2);

        // Reset in the middle of a mul
        issue(3'd5, 32'hDEAD_BEEF, 32'hFFFF_FFF1);
        idle(9);
        @(negedge clk);
        rst_i = 1'b0;
        #1;
        check("midrst_ready", {{(W-1){1'b0}}, ready_o}, W'(1));
        check("midrst_done", {{(W-1){1'b0}}, done_o}, W'(0));
        check("midrst_result", result_o, '0);
        q.delete();
        last_res   = '0;
        busy_from  = 0;
        busy_until = 0;
        start_i    = 1'b0;
        repeat (3) @(negedge clk);
        rst_i = 1'b1;
        idle(40);

        // Randomized traffic
        for (int n = 0; n < 60; n++) begin
            logic [2:0]   rop;
            logic [W-1:0] ra, rb;
            rop = 3'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = ($urandom_range(0, 2) == 0) ? W'($urandom_range(0, 300)) : W'($urandom);
            issue(rop, ra, rb);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        idle(1);

        guard = 0;
        while (q.size() != 0 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (q.size() != 0) begin
            cmp_cnt++;
            err_cnt++;
            $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
        end
        idle(3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
`default_nettype wire
